// File: rtl/pipe_mux_n.sv
// rtl/pipe_mux_n.sv - registered N:1 mux stage with valid/ready handshake and flush
// Optional one-entry skid buffer with registered ready_o: define MUX_SKID_BUF_EN.
module pipe_mux_n #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sel_err_o
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_oob;
    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_err_q, sel_err_d;

    // Out-of-range selects fall through the loop and yield all-zeros data.
    always_comb begin
        sel_data = '0;
        sel_oob  = (32'(select_i) >= 32'(NUM_IN));
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(select_i) == 32'(k)) begin
                sel_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = valid_i & ready_o & ~flush_i;
    assign deliver   = valid_o & ready_i;
    assign sel_err_d = accept & sel_oob;
    assign data_o    = data_q;
    assign sel_err_o = sel_err_q;

`ifdef MUX_SKID_BUF_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            skid_q    <= '0;
            ready_q   <= 1'b1;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            skid_q    <= skid_d;
            ready_q   <= ready_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    data_d  = sel_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && deliver) begin
                    data_d = sel_data;
                end else if (accept) begin
                    skid_d  = sel_data;
                    state_d = ST_FULL;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    data_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
            skid_d  = '0;
        end
        // Ready is decided from the next state so ready_o never looks at ready_i.
        ready_d = (state_d != ST_FULL);
    end

    assign valid_o = (state_q != ST_EMPTY);
    assign ready_o = ready_q;

`else

    logic valid_q, valid_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_data;
        end else if (deliver) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_i | ~valid_q;

`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb/tb_pipe_mux_n.sv - directed vectors, corner sequences and queue-model random run for pipe_mux_n
module tb_pipe_mux_n;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [1:0]  select_i;
    logic [127:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        sel_err_o;

    logic        flush3;
    logic [1:0]  sel3;
    logic [95:0] data3;
    logic        v3;
    logic        rdy3_o;
    logic [31:0] d3_o;
    logic        vo3;
    logic        ri3;
    logic        err3;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [4];

    pipe_mux_n #(.NUM_IN(4), .SEL_W(2), .WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .select_i(select_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .sel_err_o(sel_err_o)
    );

    pipe_mux_n #(.NUM_IN(3), .SEL_W(2), .WIDTH(32)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush3), .select_i(sel3),
        .data_i(data3), .valid_i(v3), .ready_o(rdy3_o), .data_o(d3_o),
        .valid_o(vo3), .ready_i(ri3), .sel_err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of items held by the stage (capacity 1, or 2 with skid).
    logic [31:0] mq [$];
    logic [31:0] m_last = 32'h0;
    logic        m_err = 1'b0;
    logic        m_rdy_reg = 1'b1;
    logic        m_acc;
    logic        m_del;

    function automatic logic m_ready();
`ifdef MUX_SKID_BUF_EN
        return m_rdy_reg;
`else
        return ready_i || (mq.size() == 0);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_last    = 32'h0;
            m_err     = 1'b0;
            m_rdy_reg = 1'b1;
        end else begin
            m_acc = valid_i && m_ready() && !flush_i;
            m_del = (mq.size() > 0) && ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (m_del) void'(mq.pop_front());
                if (m_acc) mq.push_back(words[select_i]);
            end
            m_err = 1'b0;
            if (mq.size() > 0) m_last = mq[0];
            m_rdy_reg = (mq.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("m_valid", {31'b0, valid_o}, {31'b0, mq.size() > 0});
        chk("m_data", data_o, m_last);
        chk("m_sel_err", {31'b0, sel_err_o}, {31'b0, m_err});
        chk("m_ready", {31'b0, ready_o}, {31'b0, m_ready()});
    end

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [1:0]  s;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    function automatic vec_t mk(logic v, logic r, logic f, logic [1:0] s,
                                logic ev, logic [31:0] ed, logic ee);
        vec_t x;
        x.v = v; x.r = r; x.f = f; x.s = s; x.ev = ev; x.ed = ed; x.ee = ee;
        return x;
    endfunction

    vec_t tbl [12];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          acc_cnt;
    logic [31:0] stable_val;

    initial begin
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        data_i   = {words[3], words[2], words[1], words[0]};
        data3    = {words[2], words[1], words[0]};
        rst = 1'b0; flush_i = 1'b0; select_i = 2'd0; valid_i = 1'b0; ready_i = 1'b1;
        flush3 = 1'b0; sel3 = 2'd0; v3 = 1'b0; ri3 = 1'b1;

        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 32'h33, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 32'h44, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h44, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 32'h33, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h33, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h33, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h33, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 1'b0);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h22, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h22, 1'b0);

        #1 rst = 1'b1;
        #2;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_sel_err", {31'b0, sel_err_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            valid_i = tbl[i].v; ready_i = tbl[i].r; flush_i = tbl[i].f; select_i = tbl[i].s;
            cyc();
            chk($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, tbl[i].ev});
            chk($sformatf("vec%0d_data", i), data_o, tbl[i].ed);
            chk($sformatf("vec%0d_sel_err", i), {31'b0, sel_err_o}, {31'b0, tbl[i].ee});
        end
        flush_i = 1'b0;

        // Downstream stall with a continuous upstream stream.
        valid_i = 1'b1; ready_i = 1'b0; acc_cnt = 0; stable_val = 32'h0;
        for (int c = 0; c < 5; c++) begin
            select_i = 2'((c + 1) % 4);
            if (ready_o) acc_cnt++;
            cyc();
            if (c == 0) stable_val = data_o;
            chk($sformatf("stall%0d_data", c), data_o, 32'h22);
            chk($sformatf("stall%0d_valid", c), {31'b0, valid_o}, 32'd1);
        end
`ifdef MUX_SKID_BUF_EN
        chk("stall_accepts", acc_cnt, 32'd2);
`else
        chk("stall_accepts", acc_cnt, 32'd1);
`endif
        valid_i = 1'b0; ready_i = 1'b1;
        cyc();
`ifdef MUX_SKID_BUF_EN
        chk("drain_valid", {31'b0, valid_o}, 32'd1);
        chk("drain_data", data_o, 32'h33);
        cyc();
`endif
        chk("drained_valid", {31'b0, valid_o}, 32'd0);

        // Flush while holding as many items as the stage can take.
        valid_i = 1'b1; ready_i = 1'b0; select_i = 2'd3;
        cyc();
        select_i = 2'd0;
        cyc();
        flush_i = 1'b1; select_i = 2'd1;
        cyc();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_valid", {31'b0, valid_o}, 32'd0);
        chk("flush_ready", {31'b0, ready_o}, 32'd1);
        cyc();
        chk("flush_after_valid", {31'b0, valid_o}, 32'd0);

        // Asynchronous reset mid-cycle while an item is held.
        valid_i = 1'b1; ready_i = 1'b0; select_i = 2'd3;
        cyc();
        valid_i = 1'b0;
        chk("pre_arst_valid", {31'b0, valid_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, valid_o}, 32'd0);
        chk("arst_data", data_o, 32'd0);
        chk("arst_ready", {31'b0, ready_o}, 32'd1);
        #2 rst = 1'b0;
        valid_i = 1'b1; ready_i = 1'b1; select_i = 2'd0;
        cyc();
        chk("post_arst_valid", {31'b0, valid_o}, 32'd1);
        chk("post_arst_data", data_o, 32'h11);
        valid_i = 1'b0;
        cyc();

        // Out-of-range select on a 3-input instance.
        v3 = 1'b1; sel3 = 2'd2;
        cyc();
        chk("n3_last_data", d3_o, 32'h33);
        chk("n3_last_err", {31'b0, err3}, 32'd0);
        sel3 = 2'd3;
        cyc();
        chk("n3_oob_data", d3_o, 32'd0);
        chk("n3_oob_err", {31'b0, err3}, 32'd1);
        chk("n3_oob_valid", {31'b0, vo3}, 32'd1);
        v3 = 1'b0;
        cyc();
        chk("n3_err_clear", {31'b0, err3}, 32'd0);
        chk("n3_hold_data", d3_o, 32'd0);
        chk("n3_idle_valid", {31'b0, vo3}, 32'd0);

        for (int n = 0; n < 10000; n++) begin
            valid_i  = 1'($urandom % 2);
            ready_i  = 1'($urandom % 2);
            flush_i  = (($urandom % 32) == 0);
            select_i = 2'($urandom % 4);
            cyc();
        end
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
